// File: rtl/lsu_ctrl_pkg.sv
// Shared types and encodings for the load/store initiator: FSM states,
// fault codes, memory RW_type encodings and access-size helpers.
package lsu_ctrl_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        FLT_OK       = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_RANGE    = 2'b10,
        FLT_ILLEGAL  = 2'b11
    } fault_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    localparam logic [2:0] RW_B  = 3'b000;
    localparam logic [2:0] RW_BU = 3'b100;

    function automatic logic [2:0] size_bytes(logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            SZ_W:    return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Request/response handshake plus data_memory port of the load/store initiator.
interface lsu_ctrl_if;
    import lsu_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_type;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic [1:0]        resp_fault;
    logic              mem_W_en;
    logic              mem_R_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_RW_type;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        output req_valid, req_we, req_addr, req_type, req_wdata, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_W_en, mem_R_en, mem_addr, mem_RW_type, mem_din
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_type, req_wdata, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_W_en, mem_R_en, mem_addr, mem_RW_type, mem_din
    );

endinterface

// File: rtl/lsu_ctrl_load_ext.sv
// Load data extension: takes the assembled bytes and sign/zero-extends them
// according to access size and the unsigned flag.
module lsu_ctrl_load_ext
    import lsu_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] raw,
    input  logic [1:0]        size,
    input  logic              uns,
    output logic [DATA_W-1:0] data
);

    function automatic logic [DATA_W-1:0] extend(logic [DATA_W-1:0] r, logic [1:0] sz, logic u);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = r[7:0];
        h = r[15:0];
        case (sz)
            SZ_B:    return u ? {{(DATA_W-8){1'b0}}, r[7:0]}   : DATA_W'(b);
            SZ_H:    return u ? {{(DATA_W-16){1'b0}}, r[15:0]} : DATA_W'(h);
            default: return r;
        endcase
    endfunction

    assign data = extend(raw, size, u_sel());

    function automatic logic u_sel();
        return uns;
    endfunction

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: checks and registers one request, drives the memory
// port for one aligned beat or N byte beats, then pulses a response.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter bit SPLIT_EN  = 1'b1
) (
    input logic       clk,
    input logic       rst_n,
    lsu_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic [1:0]        beat_q;
    logic              we_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [2:0]        type_p1;
    logic [DATA_W-1:0] wdata_p1;
    fault_e            fault_p1;
    logic              split_p1;
    logic [1:0]        last_p1;
    logic [DATA_W-1:0] buf_p1;
    logic [DATA_W-1:0] ext_data;

    logic              accept;
    logic [1:0]        sz_in;
    logic [2:0]        nbytes_in;
    logic [ADDR_W:0]   end_addr;
    logic              misalign_in;
    fault_e            fault_in;

    // Request checks; the end address is one bit wider so it never wraps.
    always_comb begin
        sz_in       = bus.req_type[1:0];
        nbytes_in   = size_bytes(sz_in);
        end_addr    = {1'b0, bus.req_addr} + {30'b0, nbytes_in} - 33'd1;
        misalign_in = (sz_in == SZ_H && bus.req_addr[0]) ||
                      (sz_in == SZ_W && bus.req_addr[1:0] != 2'b00);
        if (sz_in == SZ_X || (bus.req_we && bus.req_type[2]))
            fault_in = FLT_ILLEGAL;
        else if (end_addr >= 33'(MEM_BYTES))
            fault_in = FLT_RANGE;
        else if (!SPLIT_EN && misalign_in)
            fault_in = FLT_MISALIGN;
        else
            fault_in = FLT_OK;
    end

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d         = state_q;
        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.resp_rdata  = '0;
        bus.resp_fault  = FLT_OK;
        bus.mem_W_en    = 1'b0;
        bus.mem_R_en    = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_RW_type = '0;
        bus.mem_din     = '0;
        unique case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    state_d = (fault_in == FLT_OK) ? ST_ACCESS : ST_RESP;
            end
            ST_ACCESS: begin
                bus.mem_W_en = we_p1;
                bus.mem_R_en = !we_p1;
                bus.mem_addr = addr_p1 + ADDR_W'(beat_q);
                if (split_p1) begin
                    bus.mem_RW_type = we_p1 ? RW_B : RW_BU;
                    bus.mem_din     = we_p1 ? {24'b0, wdata_p1[{beat_q, 3'b000} +: 8]} : '0;
                end else begin
                    bus.mem_RW_type = type_p1;
                    bus.mem_din     = we_p1 ? wdata_p1 : '0;
                end
                if (beat_q == last_p1)
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_fault = fault_p1;
                if (fault_p1 == FLT_OK && !we_p1)
                    bus.resp_rdata = ext_data;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage 1: control state, reset; a reset mid-access simply abandons it.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= (state_q == ST_ACCESS && beat_q != last_p1) ? beat_q + 2'd1 : 2'd0;
        end
    end

    // Stage 1: request fields and load capture buffer, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p1    <= bus.req_we;
            addr_p1  <= bus.req_addr;
            type_p1  <= bus.req_type;
            wdata_p1 <= bus.req_wdata;
            fault_p1 <= fault_in;
            split_p1 <= misalign_in;
            last_p1  <= misalign_in ? 2'(nbytes_in - 3'd1) : 2'd0;
        end
        if (state_q == ST_ACCESS) begin
            if (split_p1)
                buf_p1[{beat_q, 3'b000} +: 8] <= bus.mem_dout[7:0];
            else
                buf_p1 <= bus.mem_dout;
        end
    end

    lsu_ctrl_load_ext u_ext (
        .raw  (buf_p1),
        .size (type_p1[1:0]),
        .uns  (type_p1[2]),
        .data (ext_data)
    );

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: byte-array memory harness, byte-level
// reference model, directed scenarios and randomized transactions.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    localparam int MEM_BYTES = 1024;

    logic clk = 1'b0;
    logic rst_n;
    logic preload;
    logic en0_seen = 1'b0;
    int   vectors = 0;
    int   fails = 0;

    logic [7:0]  mem     [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    logic [31:0] obs_addr [8];
    logic [2:0]  obs_type [8];
    logic [31:0] obs_din  [8];
    int          obs_n;

    always #5 clk = ~clk;

    lsu_ctrl_if bus ();
    lsu_ctrl_if bus0 ();

    lsu_ctrl #(.MEM_BYTES(MEM_BYTES), .SPLIT_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    lsu_ctrl #(.MEM_BYTES(MEM_BYTES), .SPLIT_EN(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    function automatic int nb(logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
    endfunction

    // Memory harness: combinational read of the low size bytes, write on clock.
    always_comb begin
        bus.mem_dout = '0;
        for (int i = 0; i < 4; i++)
            if (i < nb(bus.mem_RW_type[1:0]) && longint'(bus.mem_addr) + i < MEM_BYTES)
                bus.mem_dout[8*i +: 8] = mem[bus.mem_addr + i];
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'((i * 37 + 11) % 256);
        end else if (bus.mem_W_en) begin
            for (int i = 0; i < 4; i++)
                if (i < nb(bus.mem_RW_type[1:0]) && longint'(bus.mem_addr) + i < MEM_BYTES)
                    mem[bus.mem_addr + i] <= bus.mem_din[8*i +: 8];
        end
    end

    assign bus0.mem_dout = '0;
    always @(posedge clk) if (bus0.mem_W_en || bus0.mem_R_en) en0_seen <= 1'b1;

    // Reference model: byte-addressed memory, fault rules, expected latency.
    task automatic model_txn(input logic we, input logic [31:0] addr, input logic [2:0] typ,
                             input logic [31:0] wdata, input bit split,
                             output logic [1:0] ef, output logic [31:0] erd,
                             output int elat, output int ebeats);
        int n;
        logic [31:0] v;
        n = nb(typ[1:0]);
        erd = 32'h0;
        if (typ[1:0] == 2'b11 || (we && typ[2])) ef = 2'b11;
        else if (longint'(addr) + n - 1 >= MEM_BYTES) ef = 2'b10;
        else if (!split && (addr % n) != 0) ef = 2'b01;
        else ef = 2'b00;
        if (ef != 2'b00) begin
            elat = 1;
            ebeats = 0;
        end else begin
            ebeats = ((addr % n) == 0) ? 1 : n;
            elat = ebeats + 1;
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
                if (n < 4 && !typ[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                erd = v;
            end
        end
    endtask

    // Drives one request on the split-enabled port and records what happens.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [2:0] typ,
                          input logic [31:0] wdata, output logic [1:0] flt,
                          output logic [31:0] rd, output int lat, output bit idle_ok);
        logic rdy;
        bus.req_we = we;
        bus.req_addr = addr;
        bus.req_type = typ;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        rdy = 1'b0;
        for (int c = 0; c < 20 && !rdy; c++) begin
            rdy = bus.req_ready;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        lat = 0;
        obs_n = 0;
        flt = 2'bxx;
        rd = 32'hxxxx_xxxx;
        idle_ok = 1'b0;
        if (rdy) begin
            for (int c = 1; c <= 20; c++) begin
                if (bus.resp_valid) begin
                    lat = c;
                    flt = bus.resp_fault;
                    rd = bus.resp_rdata;
                    break;
                end
                if (bus.mem_W_en || bus.mem_R_en) begin
                    if (obs_n < 8) begin
                        obs_addr[obs_n] = bus.mem_addr;
                        obs_type[obs_n] = bus.mem_RW_type;
                        obs_din[obs_n] = bus.mem_din;
                    end
                    obs_n++;
                end
                @(posedge clk);
                #1;
            end
        end
        if (lat != 0) begin
            @(posedge clk);
            #1;
            idle_ok = !bus.resp_valid && bus.req_ready && !bus.mem_W_en && !bus.mem_R_en &&
                      bus.mem_addr == 0 && bus.mem_RW_type == 0 && bus.mem_din == 0;
        end
    endtask

    task automatic test_reset();
        vectors++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
        vectors++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %b want 0", bus.resp_valid); end
        vectors++; if (bus.resp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h want 0", bus.resp_rdata); end
        vectors++; if (bus.resp_fault !== 2'b00) begin fails++; $display("FAIL rst_fault got %b want 00", bus.resp_fault); end
        vectors++; if ({bus.mem_W_en, bus.mem_R_en, bus.mem_RW_type} !== 5'b0) begin fails++; $display("FAIL rst_mem_ctl got %b want 0", {bus.mem_W_en, bus.mem_R_en, bus.mem_RW_type}); end
        vectors++; if ({bus.mem_addr, bus.mem_din} !== 64'h0) begin fails++; $display("FAIL rst_mem_data got %h want 0", {bus.mem_addr, bus.mem_din}); end
        vectors++; if (bus0.req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready0 got %b want 1", bus0.req_ready); end
    endtask

    task automatic test_aligned();
        logic [1:0] f, ef; logic [31:0] rd, erd; int lat, elat, eb; bit ok;
        model_txn(1'b1, 32'h10, 3'b010, 32'h1122_3344, 1'b1, ef, erd, elat, eb);
        do_req(1'b1, 32'h10, 3'b010, 32'h1122_3344, f, rd, lat, ok);
        vectors++; if (f !== 2'b00 || lat != 2) begin fails++; $display("FAIL sw_aligned got fault %b lat %0d want 00 lat 2", f, lat); end
        vectors++; if (obs_n != 1 || obs_addr[0] !== 32'h10 || obs_type[0] !== 3'b010 || obs_din[0] !== 32'h1122_3344) begin
            fails++; $display("FAIL sw_beat got n %0d addr %h type %b din %h want 1 10 010 11223344", obs_n, obs_addr[0], obs_type[0], obs_din[0]); end
        vectors++; if (!ok) begin fails++; $display("FAIL sw_idle got %b want 1", ok); end
        model_txn(1'b0, 32'h10, 3'b010, 32'h0, 1'b1, ef, erd, elat, eb);
        do_req(1'b0, 32'h10, 3'b010, 32'h0, f, rd, lat, ok);
        vectors++; if (rd !== 32'h1122_3344 || lat != 2 || obs_n != 1) begin fails++; $display("FAIL lw_aligned got %h lat %0d beats %0d want 11223344 lat 2 beats 1", rd, lat, obs_n); end
        do_req(1'b0, 32'h13, 3'b000, 32'h0, f, rd, lat, ok);
        vectors++; if (rd !== 32'h0000_0011) begin fails++; $display("FAIL lb_signed got %h want 00000011", rd); end
        do_req(1'b0, 32'h13, 3'b100, 32'h0, f, rd, lat, ok);
        vectors++; if (rd !== 32'h0000_0011 || obs_type[0] !== 3'b100) begin fails++; $display("FAIL lbu got %h type %b want 00000011 100", rd, obs_type[0]); end
        model_txn(1'b1, 32'h30, 3'b000, 32'hDEAD_BE80, 1'b1, ef, erd, elat, eb);
        do_req(1'b1, 32'h30, 3'b000, 32'hDEAD_BE80, f, rd, lat, ok);
        model_txn(1'b1, 32'h32, 3'b001, 32'h0000_8001, 1'b1, ef, erd, elat, eb);
        do_req(1'b1, 32'h32, 3'b001, 32'h0000_8001, f, rd, lat, ok);
        do_req(1'b0, 32'h30, 3'b000, 32'h0, f, rd, lat, ok);
        vectors++; if (rd !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_neg got %h want ffffff80", rd); end
        do_req(1'b0, 32'h30, 3'b100, 32'h0, f, rd, lat, ok);
        vectors++; if (rd !== 32'h0000_0080) begin fails++; $display("FAIL lbu_neg got %h want 00000080", rd); end
        do_req(1'b0, 32'h32, 3'b001, 32'h0, f, rd, lat, ok);
        vectors++; if (rd !== 32'hFFFF_8001) begin fails++; $display("FAIL lh_neg got %h want ffff8001", rd); end
        do_req(1'b0, 32'h32, 3'b101, 32'h0, f, rd, lat, ok);
        vectors++; if (rd !== 32'h0000_8001) begin fails++; $display("FAIL lhu got %h want 00008001", rd); end
    endtask

    task automatic test_split();
        logic [1:0] f, ef; logic [31:0] rd, erd; int lat, elat, eb; bit ok;
        model_txn(1'b1, 32'h21, 3'b010, 32'hA1B2_C3D4, 1'b1, ef, erd, elat, eb);
        do_req(1'b1, 32'h21, 3'b010, 32'hA1B2_C3D4, f, rd, lat, ok);
        vectors++; if (f !== 2'b00 || lat != 5 || obs_n != 4) begin fails++; $display("FAIL sw_split got fault %b lat %0d beats %0d want 00 5 4", f, lat, obs_n); end
        for (int j = 0; j < 4; j++) begin
            vectors++;
            if (obs_addr[j] !== 32'h21 + j || obs_type[j] !== 3'b000 || obs_din[j] !== {24'h0, 8'(32'hA1B2_C3D4 >> (8 * j))}) begin
                fails++; $display("FAIL sw_split_beat%0d got addr %h type %b din %h", j, obs_addr[j], obs_type[j], obs_din[j]); end
        end
        do_req(1'b0, 32'h21, 3'b010, 32'h0, f, rd, lat, ok);
        vectors++; if (rd !== 32'hA1B2_C3D4 || lat != 5 || obs_type[0] !== 3'b100) begin fails++; $display("FAIL lw_split got %h lat %0d type %b want a1b2c3d4 5 100", rd, lat, obs_type[0]); end
        do_req(1'b0, 32'h23, 3'b001, 32'h0, f, rd, lat, ok);
        vectors++; if (rd !== 32'hFFFF_A1B2 || lat != 3 || obs_n != 2) begin fails++; $display("FAIL lh_split got %h lat %0d beats %0d want ffffa1b2 3 2", rd, lat, obs_n); end
        vectors++; if (!ok) begin fails++; $display("FAIL lh_split_idle got %b want 1", ok); end
    endtask

    task automatic test_faults();
        logic [31:0] fa [7];
        logic [2:0]  ft [7];
        logic        fw [7];
        logic [1:0]  fe [7];
        logic [1:0]  f, ef; logic [31:0] rd, erd; int lat, elat, eb; bit ok;
        fa[0] = MEM_BYTES - 2;   ft[0] = 3'b010; fw[0] = 1'b0; fe[0] = 2'b10;
        fa[1] = 32'h40;          ft[1] = 3'b011; fw[1] = 1'b0; fe[1] = 2'b11;
        fa[2] = 32'h40;          ft[2] = 3'b100; fw[2] = 1'b1; fe[2] = 2'b11;
        fa[3] = MEM_BYTES - 1;   ft[3] = 3'b011; fw[3] = 1'b0; fe[3] = 2'b11;
        fa[4] = 32'hFFFF_FFFE;   ft[4] = 3'b010; fw[4] = 1'b0; fe[4] = 2'b10;
        fa[5] = MEM_BYTES - 1;   ft[5] = 3'b001; fw[5] = 1'b0; fe[5] = 2'b10;
        fa[6] = MEM_BYTES - 1;   ft[6] = 3'b000; fw[6] = 1'b1; fe[6] = 2'b00;
        for (int k = 0; k < 7; k++) begin
            model_txn(fw[k], fa[k], ft[k], 32'h5A5A_5A5A, 1'b1, ef, erd, elat, eb);
            do_req(fw[k], fa[k], ft[k], 32'h5A5A_5A5A, f, rd, lat, ok);
            vectors++;
            if (f !== fe[k] || lat != ((fe[k] == 2'b00) ? 2 : 1) || obs_n != ((fe[k] == 2'b00) ? 1 : 0) || rd !== 32'h0) begin
                fails++; $display("FAIL fault_case%0d got fault %b lat %0d beats %0d rdata %h want %b", k, f, lat, obs_n, rd, fe[k]); end
        end
    endtask

    task automatic test_nosplit();
        logic rdy; int lat; logic [1:0] f;
        bus0.req_we = 1'b0; bus0.req_addr = 32'h05; bus0.req_type = 3'b001; bus0.req_wdata = '0;
        bus0.req_valid = 1'b1;
        rdy = 1'b0;
        for (int c = 0; c < 20 && !rdy; c++) begin rdy = bus0.req_ready; @(posedge clk); #1; end
        bus0.req_valid = 1'b0;
        lat = 0; f = 2'bxx;
        for (int c = 1; c <= 10 && rdy; c++) begin
            if (bus0.resp_valid) begin lat = c; f = bus0.resp_fault; break; end
            @(posedge clk); #1;
        end
        vectors++; if (f !== 2'b01 || lat != 1) begin fails++; $display("FAIL nosplit_lh got fault %b lat %0d want 01 lat 1", f, lat); end
        @(posedge clk); #1;
        vectors++; if (en0_seen !== 1'b0) begin fails++; $display("FAIL nosplit_mem_en got %b want 0", en0_seen); end
        bus0.req_addr = 32'h08; bus0.req_type = 3'b010; bus0.req_valid = 1'b1;
        @(posedge clk); #1;
        bus0.req_valid = 1'b0;
        vectors++; if (bus0.mem_R_en !== 1'b1 || bus0.mem_addr !== 32'h08) begin fails++; $display("FAIL nosplit_lw_beat got ren %b addr %h want 1 08", bus0.mem_R_en, bus0.mem_addr); end
        @(posedge clk); #1;
        vectors++; if (bus0.resp_valid !== 1'b1 || bus0.resp_fault !== 2'b00) begin fails++; $display("FAIL nosplit_lw_resp got valid %b fault %b want 1 00", bus0.resp_valid, bus0.resp_fault); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b3, b4; bit resp_seen;
        b3 = ref_mem[32'h43];
        b4 = ref_mem[32'h44];
        bus.req_we = 1'b1; bus.req_addr = 32'h41; bus.req_type = 3'b010; bus.req_wdata = 32'h5566_7788;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        vectors++; if (bus.mem_W_en !== 1'b1 || bus.mem_addr !== 32'h42) begin fails++; $display("FAIL mid_beat got wen %b addr %h want 1 42", bus.mem_W_en, bus.mem_addr); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        vectors++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.mem_W_en !== 1'b0) begin
            fails++; $display("FAIL mid_rst_idle got ready %b valid %b wen %b want 1 0 0", bus.req_ready, bus.resp_valid, bus.mem_W_en); end
        resp_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (bus.resp_valid || bus.mem_W_en) resp_seen = 1'b1;
            @(posedge clk); #1;
        end
        vectors++; if (resp_seen) begin fails++; $display("FAIL mid_rst_quiet got activity %b want 0", resp_seen); end
        vectors++; if (mem[32'h41] !== 8'h88) begin fails++; $display("FAIL mid_rst_byte0 got %h want 88", mem[32'h41]); end
        vectors++; if (mem[32'h43] !== b3 || mem[32'h44] !== b4) begin fails++; $display("FAIL mid_rst_tail got %h %h want %h %h", mem[32'h43], mem[32'h44], b3, b4); end
        ref_mem[32'h41] = 8'h88;
        ref_mem[32'h42] = mem[32'h42];
    endtask

    task automatic test_random();
        logic we; logic [31:0] addr, wdata, rd, erd, ed; logic [2:0] typ, et; logic [1:0] f, ef;
        int lat, elat, eb, r; bit ok;
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom);
            typ = 3'($urandom_range(0, 7));
            wdata = $urandom;
            r = $urandom_range(0, 9);
            if (r < 6) addr = $urandom_range(0, 127);
            else if (r < 9) addr = $urandom_range(0, MEM_BYTES - 1);
            else addr = (r % 2 == 0) ? 32'(MEM_BYTES - 4 + $urandom_range(0, 7)) : 32'hFFFF_FFF8 + $urandom_range(0, 7);
            model_txn(we, addr, typ, wdata, 1'b1, ef, erd, elat, eb);
            do_req(we, addr, typ, wdata, f, rd, lat, ok);
            vectors++;
            if (f !== ef || lat != elat || rd !== erd || obs_n != eb || !ok) begin
                fails++; $display("FAIL rand%0d we %b addr %h type %b: fault %b/%b lat %0d/%0d rdata %h/%h beats %0d/%0d idle %b",
                                  n, we, addr, typ, f, ef, lat, elat, rd, erd, obs_n, eb, ok); end
            for (int j = 0; j < eb && j < obs_n && j < 8; j++) begin
                et = (eb == 1) ? typ : (we ? 3'b000 : 3'b100);
                ed = (eb == 1) ? wdata : {24'h0, 8'(wdata >> (8 * j))};
                vectors++;
                if (obs_addr[j] !== addr + j || obs_type[j] !== et || (we && obs_din[j] !== ed)) begin
                    fails++; $display("FAIL rand%0d_beat%0d got addr %h type %b din %h want %h %b %h",
                                      n, j, obs_addr[j], obs_type[j], obs_din[j], addr + j, et, ed); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        preload = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_type = '0; bus.req_wdata = '0;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_type = '0; bus0.req_wdata = '0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'((i * 37 + 11) % 256);
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        preload = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        test_aligned();
        test_split();
        test_faults();
        test_nosplit();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
